// File: rtl/carfield_periph_apb_pkg.sv
// carfield_periph_apb_pkg
//  Shared types and the peripheral APB address map for the carfield periph
//  APB scheduler. The map mirrors the carfield_configuration bases/sizes for
//  CAN, system timer, advanced timer, watchdog and HyperBus configuration.
//  decode() returns whether an address hits one of the slaves and which one.
package carfield_periph_apb_pkg;

    typedef logic [63:0] doub_bt;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic [2:0] {
        SLV_CAN          = 3'd0,
        SLV_SYS_TIMER    = 3'd1,
        SLV_ADV_TIMER    = 3'd2,
        SLV_WATCHDOG     = 3'd3,
        SLV_HYPERBUS_CFG = 3'd4
    } slv_idx_e;

    typedef struct packed {
        slv_idx_e idx;
        doub_bt   start_addr;
        doub_bt   end_addr;
    } addr_rule_t;

    typedef struct packed {
        logic     hit;
        slv_idx_e idx;
    } decode_t;

    localparam doub_bt CanBase                 = 64'h0000_0000_2000_1000;
    localparam doub_bt CanSize                 = 64'h0000_0000_0000_1000;
    localparam doub_bt SystemTimerBase         = 64'h0000_0000_2000_4000;
    localparam doub_bt SystemTimerSize         = 64'h0000_0000_0000_1000;
    localparam doub_bt SystemAdvancedTimerBase = 64'h0000_0000_2000_5000;
    localparam doub_bt SystemAdvancedTimerSize = 64'h0000_0000_0000_1000;
    localparam doub_bt SystemWatchdogBase      = 64'h0000_0000_2000_7000;
    localparam doub_bt SystemWatchdogSize      = 64'h0000_0000_0000_1000;
    localparam doub_bt HyperBusBase            = 64'h0000_0000_2000_9000;
    localparam doub_bt HyperBusSize            = 64'h0000_0000_0000_1000;

    localparam int unsigned NumRules = 5;

    // End addresses are exclusive: a hit is start_addr <= addr < end_addr.
    localparam addr_rule_t AddrMap [NumRules] = '{
        '{SLV_CAN,          CanBase,                 CanBase + CanSize},
        '{SLV_SYS_TIMER,    SystemTimerBase,         SystemTimerBase + SystemTimerSize},
        '{SLV_ADV_TIMER,    SystemAdvancedTimerBase, SystemAdvancedTimerBase + SystemAdvancedTimerSize},
        '{SLV_WATCHDOG,     SystemWatchdogBase,      SystemWatchdogBase + SystemWatchdogSize},
        '{SLV_HYPERBUS_CFG, HyperBusBase,            HyperBusBase + HyperBusSize}
    };

    // The CAN window is treated as unmapped when CAN is not built in, so
    // accesses to it fail fast instead of hanging on an absent slave.
    function automatic decode_t decode(input doub_bt addr, input logic can_en);
        decode_t res;
        res.hit = 1'b0;
        res.idx = SLV_CAN;
        for (int i = 0; i < NumRules; i++) begin
            if (!res.hit &&
                (addr >= AddrMap[i].start_addr) &&
                (addr <  AddrMap[i].end_addr) &&
                (can_en || (AddrMap[i].idx != SLV_CAN))) begin
                res.hit = 1'b1;
                res.idx = AddrMap[i].idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/carfield_periph_rr_pick.sv
// carfield_periph_rr_pick
//  Round-robin requester selection. Holds the RR pointer and picks the first
//  requesting index at or after it. When advance_i is high and a pick is
//  valid, the pointer moves to one past the picked index.
// Ports
//  clk_i      clock
//  rst_i      async reset, active-high (pointer returns to 0)
//  req_i      NumReq request vector
//  advance_i  pick is being consumed this cycle
//  idx_o      selected requester index
//  valid_o    at least one request present
module carfield_periph_rr_pick #(
    parameter int unsigned NumReq = 2,
    localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    input  logic              advance_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] cand_idx;
    int unsigned     cand;

    always_comb begin
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand     = (32'(ptr_q) + i) % NumReq;
            cand_idx = IdxW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (advance_i && valid_o) begin
            ptr_q <= (idx_o == IdxW'(NumReq - 1)) ? '0 : IdxW'(idx_o + 1'b1);
        end
    end

endmodule

// File: rtl/carfield_periph_apb_scheduler.sv
// carfield_periph_apb_scheduler
//  Shares the carfield peripheral APB segment between NumReq requesters.
//  Round-robin arbitrates, decodes the address against the peripheral map and
//  runs one APB transfer at a time. Unmapped addresses and slaves that never
//  assert pready are answered with an error response.
// Ports
//  clk_i / rst_i        clock, async active-high reset
//  req_i, addr_i, we_i, wdata_i, strb_i
//                       per-requester request and payload, held until rsp_valid_o
//  gnt_o                one-cycle grant pulse to the chosen requester
//  rsp_valid_o          one-cycle response pulse to the owner
//  rsp_rdata_o, rsp_err_o
//                       response data/error, valid with rsp_valid_o
//  psel_o .. pstrb_o    APB master side (psel one-hot over the slaves)
//  prdata_i, pready_i, pslverr_i
//                       per-slave APB responses
//  timeout_irq_o        sticky flag set on a slave timeout
//  timeout_clr_i        clears timeout_irq_o (a simultaneous set wins)
module carfield_periph_apb_scheduler
    import carfield_periph_apb_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned NumSlv        = 5,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 256,
    parameter bit          CanEnable     = 1'b1,
    localparam int unsigned IdxW         = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned StrbW        = DataWidth / 8,
    localparam int unsigned CntW         = $clog2(TimeoutCycles)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumReq-1:0]                 req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]  addr_i,
    input  logic [NumReq-1:0]                 we_i,
    input  logic [NumReq-1:0][DataWidth-1:0]  wdata_i,
    input  logic [NumReq-1:0][StrbW-1:0]      strb_i,
    output logic [NumReq-1:0]                 gnt_o,
    output logic [NumReq-1:0]                 rsp_valid_o,
    output logic [DataWidth-1:0]              rsp_rdata_o,
    output logic                              rsp_err_o,
    output logic [NumSlv-1:0]                 psel_o,
    output logic                              penable_o,
    output logic                              pwrite_o,
    output logic [AddrWidth-1:0]              paddr_o,
    output logic [DataWidth-1:0]              pwdata_o,
    output logic [StrbW-1:0]                  pstrb_o,
    input  logic [NumSlv-1:0][DataWidth-1:0]  prdata_i,
    input  logic [NumSlv-1:0]                 pready_i,
    input  logic [NumSlv-1:0]                 pslverr_i,
    output logic                              timeout_irq_o,
    input  logic                              timeout_clr_i
);

    state_e               state_q, state_d;
    logic [IdxW-1:0]      pick_idx;
    logic                 pick_valid;
    logic                 grant;
    decode_t              dec;

    logic [IdxW-1:0]      owner_q;
    logic [AddrWidth-1:0] addr_q;
    logic                 we_q;
    logic [DataWidth-1:0] wdata_q;
    logic [StrbW-1:0]     strb_q;
    slv_idx_e             slv_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 err_q;
    logic [CntW-1:0]      cnt_q;
    logic                 irq_q;

    logic                 slv_ready;
    logic                 timeout_hit;

    carfield_periph_rr_pick #(
        .NumReq (NumReq)
    ) i_rr_pick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .advance_i (state_q == IDLE),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

    // Decode the candidate's live address so IDLE can already choose between
    // SETUP and a direct error response.
    assign dec         = decode(doub_bt'(addr_i[pick_idx]), CanEnable);
    assign grant       = (state_q == IDLE) && pick_valid;
    assign slv_ready   = pready_i[slv_q];
    assign timeout_hit = (state_q == ACCESS) && !slv_ready &&
                         (cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = dec.hit ? SETUP : RESP;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (slv_ready || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_o       = '0;
        rsp_valid_o = '0;
        psel_o      = '0;
        penable_o   = 1'b0;
        if (grant) begin
            gnt_o[pick_idx] = 1'b1;
        end
        if ((state_q == SETUP) || (state_q == ACCESS)) begin
            psel_o[slv_q] = 1'b1;
        end
        if (state_q == ACCESS) begin
            penable_o = 1'b1;
        end
        if (state_q == RESP) begin
            rsp_valid_o[owner_q] = 1'b1;
        end
    end

    // Payload is captured once at grant; the requester's inputs are ignored
    // from then on, which keeps the APB signals stable through ACCESS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            slv_q   <= SLV_CAN;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (grant) begin
            owner_q <= pick_idx;
            addr_q  <= addr_i[pick_idx];
            we_q    <= we_i[pick_idx];
            wdata_q <= wdata_i[pick_idx];
            strb_q  <= strb_i[pick_idx];
            slv_q   <= dec.idx;
            rdata_q <= '0;
            err_q   <= !dec.hit;
        end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end else if ((state_q == ACCESS) && slv_ready) begin
            rdata_q <= prdata_i[slv_q];
            err_q   <= pslverr_i[slv_q];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if ((state_q == ACCESS) && !slv_ready && !timeout_hit) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // Set has priority so a timeout coinciding with a clear is not lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else if (timeout_hit) begin
            irq_q <= 1'b1;
        end else if (timeout_clr_i) begin
            irq_q <= 1'b0;
        end
    end

    assign paddr_o       = addr_q;
    assign pwrite_o      = we_q;
    assign pwdata_o      = we_q ? wdata_q : '0;
    assign pstrb_o       = we_q ? strb_q : '0;
    assign rsp_rdata_o   = (state_q == RESP) ? rdata_q : '0;
    assign rsp_err_o     = (state_q == RESP) && err_q;
    assign timeout_irq_o = irq_q;

endmodule

// File: tb/tb_carfield_periph_apb_scheduler.sv
// tb_carfield_periph_apb_scheduler
//  Directed bench for the periph APB scheduler with a behavioural APB slave
//  whose wait states, rdata and slverr are set per transfer.
module tb_carfield_periph_apb_scheduler;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [1:0]       req_i;
    logic [1:0][31:0] addr_i;
    logic [1:0]       we_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0][3:0]  strb_i;
    logic [1:0]       gnt_o;
    logic [1:0]       rsp_valid_o;
    logic [31:0]      rsp_rdata_o;
    logic             rsp_err_o;
    logic [4:0]       psel_o;
    logic             penable_o;
    logic             pwrite_o;
    logic [31:0]      paddr_o;
    logic [31:0]      pwdata_o;
    logic [3:0]       pstrb_o;
    logic [4:0][31:0] prdata_i;
    logic [4:0]       pready_i;
    logic [4:0]       pslverr_i;
    logic             timeout_irq_o;
    logic             timeout_clr_i;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int          ready_wait  = 0;
    logic        slv_err_v   = 1'b0;
    logic [31:0] slv_rdata_v = '0;
    int          acc_cnt     = 0;
    logic        slv_ready;

    int          t_gnt, t_rsp, t_psel, t_pen, acc_cycles;
    logic [4:0]  psel_val, psel_seen, psel_at_rsp;
    logic [31:0] obs_paddr, obs_pwdata, obs_rdata;
    logic [3:0]  obs_pstrb;
    logic        obs_pwrite, obs_err, obs_irq, got_rsp;

    carfield_periph_apb_scheduler #(
        .NumReq        (2),
        .NumSlv        (5),
        .AddrWidth     (32),
        .DataWidth     (32),
        .TimeoutCycles (8),
        .CanEnable     (1'b0)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .addr_i        (addr_i),
        .we_i          (we_i),
        .wdata_i       (wdata_i),
        .strb_i        (strb_i),
        .gnt_o         (gnt_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .pwrite_o      (pwrite_o),
        .paddr_o       (paddr_o),
        .pwdata_o      (pwdata_o),
        .pstrb_o       (pstrb_o),
        .prdata_i      (prdata_i),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i),
        .timeout_irq_o (timeout_irq_o),
        .timeout_clr_i (timeout_clr_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Slave answers after ready_wait stalled ACCESS cycles.
    always @(posedge clk_i) begin
        if (penable_o && !slv_ready) acc_cnt <= acc_cnt + 1;
        else                         acc_cnt <= 0;
    end

    assign slv_ready = penable_o && (acc_cnt >= ready_wait);
    assign pready_i  = slv_ready ? psel_o : 5'b0;
    assign prdata_i  = {5{slv_rdata_v}};
    assign pslverr_i = {5{slv_err_v}};

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One transfer from one port; records timing and APB observations.
    task automatic applyStimulus(input int port, input logic [31:0] addr, input logic we,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input int rwait, input logic serr, input logic [31:0] srdata);
        ready_wait  = rwait;
        slv_err_v   = serr;
        slv_rdata_v = srdata;
        t_gnt = -1; t_rsp = -1; t_psel = -1; t_pen = -1; acc_cycles = 0;
        psel_seen = '0; psel_val = '0; psel_at_rsp = '0; got_rsp = 1'b0;
        @(posedge clk_i); #1;
        req_i[port]   = 1'b1;
        addr_i[port]  = addr;
        we_i[port]    = we;
        wdata_i[port] = wdata;
        strb_i[port]  = strb;
        for (int i = 0; i < 100 && !got_rsp; i++) begin
            @(negedge clk_i);
            if (gnt_o[port] && t_gnt < 0) t_gnt = cyc;
            psel_seen = psel_seen | psel_o;
            if (psel_o != 0 && t_psel < 0) begin
                t_psel   = cyc;
                psel_val = psel_o;
            end
            if (penable_o) begin
                acc_cycles++;
                if (t_pen < 0) begin
                    t_pen      = cyc;
                    obs_paddr  = paddr_o;
                    obs_pwdata = pwdata_o;
                    obs_pstrb  = pstrb_o;
                    obs_pwrite = pwrite_o;
                end
            end
            if (rsp_valid_o[port]) begin
                got_rsp     = 1'b1;
                t_rsp       = cyc;
                obs_rdata   = rsp_rdata_o;
                obs_err     = rsp_err_o;
                obs_irq     = timeout_irq_o;
                psel_at_rsp = psel_o;
                req_i[port] = 1'b0;
            end
        end
        if (!got_rsp) begin
            req_i[port] = 1'b0;
            checkOutput("rsp_bound", 64'(got_rsp), 64'd1);
        end
    endtask

    logic [1:0] gnt_log [8];
    logic [1:0] rsp_log [8];
    int         n_gnt, n_rsp;
    logic       seen_pen, rsp_during;

    initial begin
        rst_i = 1'b1; req_i = '0; addr_i = '0; we_i = '0; wdata_i = '0; strb_i = '0;
        timeout_clr_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_gnt",   64'(gnt_o),         64'd0);
        checkOutput("rst_rsp",   64'(rsp_valid_o),   64'd0);
        checkOutput("rst_psel",  64'(psel_o),        64'd0);
        checkOutput("rst_pen",   64'(penable_o),     64'd0);
        checkOutput("rst_irq",   64'(timeout_irq_o), 64'd0);
        checkOutput("rst_paddr", 64'(paddr_o),       64'd0);
        rst_i = 1'b0;

        // single zero-wait write to the system timer
        applyStimulus(0, 32'h2000_4010, 1'b1, 32'hA5A5_A5A5, 4'hF, 0, 1'b0, 32'h0);
        checkOutput("wr_psel_lat", 64'(t_psel - t_gnt), 64'd1);
        checkOutput("wr_pen_lat",  64'(t_pen - t_gnt),  64'd2);
        checkOutput("wr_rsp_lat",  64'(t_rsp - t_gnt),  64'd3);
        checkOutput("wr_psel",     64'(psel_val),       64'h02);
        checkOutput("wr_paddr",    64'(obs_paddr),      64'h2000_4010);
        checkOutput("wr_pwdata",   64'(obs_pwdata),     64'hA5A5_A5A5);
        checkOutput("wr_pstrb",    64'(obs_pstrb),      64'hF);
        checkOutput("wr_pwrite",   64'(obs_pwrite),     64'd1);
        checkOutput("wr_err",      64'(obs_err),        64'd0);

        // zero-wait read from port 1: write data must be masked
        applyStimulus(1, 32'h2000_5008, 1'b0, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'hDEAD_BEEF);
        checkOutput("rd_rsp_lat", 64'(t_rsp - t_gnt), 64'd3);
        checkOutput("rd_psel",    64'(psel_val),      64'h04);
        checkOutput("rd_rdata",   64'(obs_rdata),     64'hDEAD_BEEF);
        checkOutput("rd_pwdata",  64'(obs_pwdata),    64'h0);
        checkOutput("rd_pstrb",   64'(obs_pstrb),     64'h0);
        checkOutput("rd_pwrite",  64'(obs_pwrite),    64'd0);

        // decode misses: hole in the map and CAN with CanEnable=0
        applyStimulus(0, 32'h2000_3000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h5555_5555);
        checkOutput("miss_lat",   64'(t_rsp - t_gnt), 64'd1);
        checkOutput("miss_err",   64'(obs_err),       64'd1);
        checkOutput("miss_rdata", 64'(obs_rdata),     64'd0);
        checkOutput("miss_psel",  64'(psel_seen),     64'd0);
        applyStimulus(1, 32'h2000_1000, 1'b1, 32'h1, 4'h1, 0, 1'b0, 32'h5555_5555);
        checkOutput("can_lat",    64'(t_rsp - t_gnt), 64'd1);
        checkOutput("can_err",    64'(obs_err),       64'd1);
        checkOutput("can_rdata",  64'(obs_rdata),     64'd0);
        checkOutput("can_psel",   64'(psel_seen),     64'd0);

        // watchdog read with two wait states and slverr
        applyStimulus(0, 32'h2000_7004, 1'b0, 32'h0, 4'h0, 2, 1'b1, 32'h0000_1234);
        checkOutput("ws_lat",   64'(t_rsp - t_gnt), 64'd5);
        checkOutput("ws_psel",  64'(psel_val),      64'h08);
        checkOutput("ws_acc",   64'(acc_cycles),    64'd3);
        checkOutput("ws_err",   64'(obs_err),       64'd1);
        checkOutput("ws_rdata", 64'(obs_rdata),     64'h1234);

        // HyperBus cfg slave never ready: timeout after 8 ACCESS cycles
        applyStimulus(1, 32'h2000_9000, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'hCAFE_F00D);
        checkOutput("to_acc",      64'(acc_cycles),    64'd8);
        checkOutput("to_lat",      64'(t_rsp - t_gnt), 64'd10);
        checkOutput("to_psel",     64'(psel_val),      64'h10);
        checkOutput("to_psel_rsp", 64'(psel_at_rsp),   64'd0);
        checkOutput("to_err",      64'(obs_err),       64'd1);
        checkOutput("to_rdata",    64'(obs_rdata),     64'd0);
        checkOutput("to_irq_rsp",  64'(obs_irq),       64'd1);
        repeat (3) @(negedge clk_i);
        checkOutput("to_irq_hold", 64'(timeout_irq_o), 64'd1);
        @(posedge clk_i); #1;
        timeout_clr_i = 1'b1;
        @(negedge clk_i);
        checkOutput("to_irq_preclr", 64'(timeout_irq_o), 64'd1);
        @(posedge clk_i); #1;
        timeout_clr_i = 1'b0;
        @(negedge clk_i);
        checkOutput("to_irq_clr", 64'(timeout_irq_o), 64'd0);

        // timeout while clear is held: set wins, then clears next cycle
        timeout_clr_i = 1'b1;
        applyStimulus(0, 32'h2000_9000, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'h0);
        checkOutput("setclr_irq", 64'(obs_irq), 64'd1);
        @(negedge clk_i);
        checkOutput("setclr_after", 64'(timeout_irq_o), 64'd0);
        timeout_clr_i = 1'b0;

        // round-robin contention from reset
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        ready_wait = 0; slv_err_v = 1'b0; slv_rdata_v = 32'h0;
        n_gnt = 0; n_rsp = 0;
        @(posedge clk_i); #1;
        addr_i[0] = 32'h2000_5000; addr_i[1] = 32'h2000_5004; we_i = 2'b00;
        req_i = 2'b11;
        for (int i = 0; i < 200 && n_rsp < 4; i++) begin
            @(negedge clk_i);
            if (gnt_o != 0 && n_gnt < 8) begin
                gnt_log[n_gnt] = gnt_o;
                n_gnt++;
            end
            if (rsp_valid_o != 0 && n_rsp < 8) begin
                rsp_log[n_rsp] = rsp_valid_o;
                n_rsp++;
                if (n_rsp == 4) req_i = 2'b00;
            end
        end
        req_i = 2'b00;
        checkOutput("rr_ngnt", 64'(n_gnt), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rr_gnt%0d", i), 64'(gnt_log[i]), (i % 2 == 0) ? 64'h1 : 64'h2);
            checkOutput($sformatf("rr_rsp%0d", i), 64'(rsp_log[i]), (i % 2 == 0) ? 64'h1 : 64'h2);
        end

        // async reset in the middle of a stalled ACCESS
        ready_wait = 1000;
        seen_pen = 1'b0;
        @(posedge clk_i); #1;
        addr_i[0] = 32'h2000_7000; we_i[0] = 1'b0; req_i[0] = 1'b1;
        for (int i = 0; i < 20 && !seen_pen; i++) begin
            @(negedge clk_i);
            if (penable_o) seen_pen = 1'b1;
        end
        checkOutput("mr_access", 64'(seen_pen), 64'd1);
        @(negedge clk_i);
        rst_i = 1'b1; req_i = 2'b00;
        #1;
        checkOutput("mr_psel", 64'(psel_o),    64'd0);
        checkOutput("mr_pen",  64'(penable_o), 64'd0);
        rsp_during = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            if (rsp_valid_o != 0) rsp_during = 1'b1;
        end
        checkOutput("mr_no_rsp", 64'(rsp_during),    64'd0);
        checkOutput("mr_no_irq", 64'(timeout_irq_o), 64'd0);
        rst_i = 1'b0;
        applyStimulus(0, 32'h2000_4004, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_CAFE);
        checkOutput("mr_next_lat",   64'(t_rsp - t_gnt), 64'd3);
        checkOutput("mr_next_rdata", 64'(obs_rdata),     64'h0BAD_CAFE);
        checkOutput("mr_next_err",   64'(obs_err),       64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
